// File: rtl/accumulator_datapath.sv
// Accumulator datapath: PC/IR/D/AC registers plus word memory, driven by controller strobes.
// Optional feature: define ACC_SAT_EN for saturating accumulator arithmetic (wraps otherwise).
module accumulator_datapath #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              LD_PC,
    input  logic              PC_CNT,
    input  logic              LD_IR,
    input  logic              LD_D,
    input  logic              LD_AC,
    input  logic              ADDSUB,
    input  logic              CL_AC,
    input  logic              CL,
    input  logic              DORPC,
    input  logic              MEM_EN,
    input  logic              RORW,
    input  logic              PROG_WE,
    input  logic [ADDR_W-1:0] PROG_ADDR,
    input  logic [DATA_W-1:0] PROG_DATA,
    output logic [DATA_W-1:0] MEM_RDATA,
    output logic              ADD,
    output logic              SUB,
    output logic              STORE,
    output logic              BNZ,
    output logic              CLR,
    output logic              ZERO,
    output logic              OVERFLOW,
    output logic [ADDR_W-1:0] PC_OUT,
    output logic [DATA_W-1:0] AC_OUT
);
    localparam int MSB   = DATA_W - 1;
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [2:0] {
        OP_NOP   = 3'b000,
        OP_ADD   = 3'b001,
        OP_SUB   = 3'b010,
        OP_STORE = 3'b011,
        OP_BNZ   = 3'b100,
        OP_CLR   = 3'b101
    } opcode_e;

    logic [ADDR_W-1:0] pc_q, pc_d, mem_addr;
    logic [DATA_W-1:0] ir_q, ir_d, d_q, d_d, ac_q, ac_d, rdata_q, rdata_d;
    logic [DATA_W-1:0] alu_raw, alu_res;
    logic              ovf_q, ovf_d, alu_ovf;
    logic              mem_we, prog_we;
    logic [DATA_W-1:0] mem [DEPTH];
    opcode_e           opcode;

    assign mem_addr = DORPC ? ir_q[ADDR_W-1:0] : pc_q;
    // Reset suppresses both write paths so an in-flight store never lands.
    assign mem_we   = MEM_EN && !RORW && !RESET;
    assign prog_we  = !MEM_EN && PROG_WE && !RESET;

    // Signed overflow: add with like-signed operands, or subtract with unlike-signed
    // operands, where the result sign departs from the AC sign.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        alu_raw = ADDSUB ? (ac_q - d_q) : (ac_q + d_q);
        alu_ovf = 1'b0;
        if (ADDSUB) alu_ovf = (ac_q[MSB] != d_q[MSB]) && (alu_raw[MSB] != ac_q[MSB]);
        else        alu_ovf = (ac_q[MSB] == d_q[MSB]) && (alu_raw[MSB] != ac_q[MSB]);
`ifdef ACC_SAT_EN
        alu_res = alu_raw;
        if (alu_ovf) alu_res = ac_q[MSB] ? {1'b1, {(DATA_W-1){1'b0}}}
                                         : {1'b0, {(DATA_W-1){1'b1}}};
`else
        alu_res = alu_raw;
`endif
    end

    always_comb begin
        pc_d    = pc_q;
        ir_d    = ir_q;
        d_d     = d_q;
        ac_d    = ac_q;
        rdata_d = rdata_q;
        ovf_d   = ovf_q && !CL;
        if (LD_PC)       pc_d = ir_q[ADDR_W-1:0];
        else if (PC_CNT) pc_d = pc_q + ADDR_W'(1);
        if (LD_IR) ir_d = rdata_q;
        if (LD_D)  d_d  = rdata_q;
        if (CL_AC) begin
            ac_d = '0;
        end else if (LD_AC) begin
            ac_d = alu_res;
            if (alu_ovf) ovf_d = 1'b1;
        end
        if (MEM_EN && RORW) rdata_d = mem[mem_addr];
    end

    always_ff @(posedge CLK) begin
        // NOTE: registers use non-blocking assignments so all see pre-edge values.
        if (RESET) begin
            pc_q    <= '0;
            ir_q    <= '0;
            d_q     <= '0;
            ac_q    <= '0;
            rdata_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            d_q     <= d_d;
            ac_q    <= ac_d;
            rdata_q <= rdata_d;
            ovf_q   <= ovf_d;
        end
    end

    // NOTE: the memory array is deliberately left out of reset so it maps to RAM.
    always_ff @(posedge CLK) begin
        if (mem_we)       mem[mem_addr]  <= ac_q;
        else if (prog_we) mem[PROG_ADDR] <= PROG_DATA;
    end

    // Flags decode straight from the IR register, so they follow IR one edge after LD_IR.
    assign opcode    = opcode_e'(ir_q[MSB -: 3]);
    assign ADD       = (opcode == OP_ADD);
    assign SUB       = (opcode == OP_SUB);
    assign STORE     = (opcode == OP_STORE);
    assign BNZ       = (opcode == OP_BNZ);
    assign CLR       = (opcode == OP_CLR);
    assign ZERO      = (ac_q == '0);
    assign OVERFLOW  = ovf_q;
    assign MEM_RDATA = rdata_q;
    assign PC_OUT    = pc_q;
    assign AC_OUT    = ac_q;
endmodule

// File: tb/tb_accumulator_datapath.sv
// Self-checking bench for accumulator_datapath: directed scenarios then randomized strobes
// against an integer-arithmetic reference model.
module tb_accumulator_datapath;
    localparam int DW    = 8;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic          CLK = 1'b0;
    logic          RESET, LD_PC, PC_CNT, LD_IR, LD_D, LD_AC, ADDSUB, CL_AC, CL;
    logic          DORPC, MEM_EN, RORW, PROG_WE;
    logic [AW-1:0] PROG_ADDR, PC_OUT;
    logic [DW-1:0] PROG_DATA, MEM_RDATA, AC_OUT;
    logic          ADD, SUB, STORE, BNZ, CLR, ZERO, OVERFLOW;

    accumulator_datapath #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .CLK(CLK), .RESET(RESET), .LD_PC(LD_PC), .PC_CNT(PC_CNT), .LD_IR(LD_IR),
        .LD_D(LD_D), .LD_AC(LD_AC), .ADDSUB(ADDSUB), .CL_AC(CL_AC), .CL(CL),
        .DORPC(DORPC), .MEM_EN(MEM_EN), .RORW(RORW), .PROG_WE(PROG_WE),
        .PROG_ADDR(PROG_ADDR), .PROG_DATA(PROG_DATA), .MEM_RDATA(MEM_RDATA),
        .ADD(ADD), .SUB(SUB), .STORE(STORE), .BNZ(BNZ), .CLR(CLR), .ZERO(ZERO),
        .OVERFLOW(OVERFLOW), .PC_OUT(PC_OUT), .AC_OUT(AC_OUT)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state held as plain integers.
    int m_pc, m_ir, m_d, m_ac, m_rd, m_ovf;
    int m_mem [DEPTH];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int to_signed(input int v);
        return (v >= 128) ? v - 256 : v;
    endfunction

    task automatic idle();
        RESET = 0; LD_PC = 0; PC_CNT = 0; LD_IR = 0; LD_D = 0; LD_AC = 0; ADDSUB = 0;
        CL_AC = 0; CL = 0; DORPC = 0; MEM_EN = 0; RORW = 0; PROG_WE = 0;
        PROG_ADDR = '0; PROG_DATA = '0;
    endtask

    task automatic check_all();
        int op;
        op = m_ir / 32;
        check("pc", 32'(PC_OUT), m_pc);
        check("ac", 32'(AC_OUT), m_ac);
        check("zero", 32'(ZERO), (m_ac == 0) ? 1 : 0);
        check("ovf", 32'(OVERFLOW), m_ovf);
        check("rdata", 32'(MEM_RDATA), m_rd);
        check("flag_add", 32'(ADD), (op == 1) ? 1 : 0);
        check("flag_sub", 32'(SUB), (op == 2) ? 1 : 0);
        check("flag_store", 32'(STORE), (op == 3) ? 1 : 0);
        check("flag_bnz", 32'(BNZ), (op == 4) ? 1 : 0);
        check("flag_clr", 32'(CLR), (op == 5) ? 1 : 0);
    endtask

    // One clock: derive next model state from the present inputs, clock, then compare.
    task automatic step();
        int addr, r, res, ov;
        int n_pc, n_ir, n_d, n_ac, n_rd, n_ovf;
        addr = DORPC ? (m_ir % DEPTH) : m_pc;
        r    = to_signed(m_ac) + (ADDSUB ? -to_signed(m_d) : to_signed(m_d));
        ov   = (r > 127 || r < -128) ? 1 : 0;
`ifdef ACC_SAT_EN
        res  = ov ? ((r > 0) ? 127 : 128) : (r & 255);
`else
        res  = r & 255;
`endif
        if (RESET) begin
            n_pc = 0; n_ir = 0; n_d = 0; n_ac = 0; n_rd = 0; n_ovf = 0;
        end else begin
            n_rd  = (MEM_EN && RORW) ? m_mem[addr] : m_rd;
            n_pc  = LD_PC ? (m_ir % DEPTH) : (PC_CNT ? (m_pc + 1) % DEPTH : m_pc);
            n_ir  = LD_IR ? m_rd : m_ir;
            n_d   = LD_D ? m_rd : m_d;
            n_ac  = CL_AC ? 0 : (LD_AC ? res : m_ac);
            n_ovf = ((m_ovf == 1 && !CL) || (LD_AC && !CL_AC && ov == 1)) ? 1 : 0;
            if (MEM_EN && !RORW)       m_mem[addr] = m_ac;
            else if (!MEM_EN && PROG_WE) m_mem[int'(PROG_ADDR)] = int'(PROG_DATA);
        end
        @(posedge CLK);
        #1;
        m_pc = n_pc; m_ir = n_ir; m_d = n_d; m_ac = n_ac; m_rd = n_rd; m_ovf = n_ovf;
        check_all();
    endtask

    task automatic do_reset();
        idle(); RESET = 1; step(); idle();
    endtask

    task automatic prog(input int a, input int d);
        idle(); PROG_WE = 1; PROG_ADDR = AW'(a); PROG_DATA = DW'(d); step(); idle();
    endtask

    task automatic fetch();
        idle(); MEM_EN = 1; RORW = 1; step(); idle(); LD_IR = 1; step(); idle();
    endtask

    task automatic load_d();
        idle(); MEM_EN = 1; RORW = 1; DORPC = 1; step(); idle(); LD_D = 1; step(); idle();
    endtask

    initial begin
        idle();
        // Reset state
        do_reset();
        check("t1_pc", 32'(PC_OUT), 0);
        check("t1_ac", 32'(AC_OUT), 0);
        check("t1_zero", 32'(ZERO), 1);
        check("t1_ovf", 32'(OVERFLOW), 0);
        check("t1_flags", 32'({ADD, SUB, STORE, BNZ, CLR}), 0);
        for (int i = 0; i < DEPTH; i++) prog(i, 0);

        // ADD 3 then STORE 4 with readback
        do_reset();
        prog(0, 'h23); prog(3, 'h05); prog(1, 'h64); prog(4, 'h00);
        fetch();
        check("t2_add", 32'(ADD), 1);
        load_d();
        LD_AC = 1; step(); idle();
        check("t2_ac", 32'(AC_OUT), 'h05);
        check("t2_zero", 32'(ZERO), 0);
        PC_CNT = 1; step(); idle();
        fetch();
        check("t4_store", 32'(STORE), 1);
        MEM_EN = 1; RORW = 0; DORPC = 1; step(); idle();
        MEM_EN = 1; RORW = 1; DORPC = 1; step(); idle();
        check("t4_readback", 32'(MEM_RDATA), 'h05);

        // CL_AC beats LD_AC; controller access blocks program write
        LD_AC = 1; CL_AC = 1; step(); idle();
        check("t6_ac_clr", 32'(AC_OUT), 0);
        MEM_EN = 1; RORW = 1; DORPC = 1; PROG_WE = 1; PROG_ADDR = 5'd4; PROG_DATA = 8'hEE;
        step(); idle();
        MEM_EN = 1; RORW = 1; DORPC = 1; step(); idle();
        check("t6_mem_kept", 32'(MEM_RDATA), 'h05);

        // Signed overflow at 0x7F + 1, sticky through CL_AC, cleared by CL
        do_reset();
        prog(0, 'h2A); prog(10, 'h7F); prog(1, 'h2B); prog(11, 'h01);
        fetch(); load_d();
        LD_AC = 1; step(); idle();
        check("t3_ac_7f", 32'(AC_OUT), 'h7F);
        check("t3_no_ovf", 32'(OVERFLOW), 0);
        PC_CNT = 1; step(); idle();
        fetch(); load_d();
        LD_AC = 1; step(); idle();
`ifdef ACC_SAT_EN
        check("t3_ac_ovf", 32'(AC_OUT), 'h7F);
`else
        check("t3_ac_ovf", 32'(AC_OUT), 'h80);
`endif
        check("t3_ovf_set", 32'(OVERFLOW), 1);
        CL_AC = 1; step(); idle();
        check("t3_ovf_after_clac", 32'(OVERFLOW), 1);
        CL = 1; step(); idle();
        check("t3_ovf_clr", 32'(OVERFLOW), 0);

        // PC wrap and LD_PC priority
        do_reset();
        prog(0, 'h8A);
        fetch();
        for (int i = 0; i < 31; i++) begin
            PC_CNT = 1; step(); idle();
        end
        check("t5_pc31", 32'(PC_OUT), 31);
        PC_CNT = 1; step(); idle();
        check("t5_wrap", 32'(PC_OUT), 0);
        LD_PC = 1; PC_CNT = 1; step(); idle();
        check("t5_ldpc", 32'(PC_OUT), 10);
        check("t5_bnz", 32'(BNZ), 1);

        // Randomized strobes
        do_reset();
        for (int i = 0; i < DEPTH; i++) prog(i, int'($urandom_range(0, 255)));
        for (int n = 0; n < 3000; n++) begin
            int sel;
            idle();
            RESET   = ($urandom_range(0, 63) == 0);
            LD_PC   = ($urandom_range(0, 7) == 0);
            PC_CNT  = ($urandom_range(0, 2) == 0);
            LD_IR   = ($urandom_range(0, 3) == 0);
            LD_D    = ($urandom_range(0, 3) == 0);
            sel     = int'($urandom_range(0, 7));
            LD_AC   = (sel <= 2);
            CL_AC   = (sel == 3);
            ADDSUB  = $urandom_range(0, 1) == 1;
            CL      = ($urandom_range(0, 15) == 0);
            DORPC   = $urandom_range(0, 1) == 1;
            MEM_EN  = $urandom_range(0, 1) == 1;
            RORW    = $urandom_range(0, 1) == 1;
            PROG_WE = ($urandom_range(0, 3) == 0);
            PROG_ADDR = AW'($urandom_range(0, DEPTH - 1));
            PROG_DATA = DW'($urandom_range(0, 255));
            step();
        end
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
